// File: rtl/fifo_stream_reader.sv
// Drains an upstream FIFO with registered read data into a valid/ready stream through a 2-entry skid buffer.
// Optional macro FIFO_STREAM_READER_CNT_EN adds a 16-bit popped-word counter output (word_count).
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic                  inflight_q, inflight_d;
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0]      m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  pop_s;
  logic                  capture_s;
  logic [2:0]            pending_s;

  assign pop_s     = m_valid_q && m_ready;
  assign capture_s = inflight_q;

  // Words already owned (buffered or in flight) after this cycle's pop; a new read is safe below 2.
  assign pending_s  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign fifo_rd_en = !rst && !fifo_empty && (pending_s < 3'd2);

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_d      = mem_q;
    inflight_d = fifo_rd_en;

    if (capture_s) begin
      mem_d[tail_q] = fifo_dout;
      tail_d        = ~tail_q;
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = ~head_q;
    end else begin
      head_d = head_q;
    end

    case ({capture_s, pop_s})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
      2'b01:   occ_d = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      2'b11:   occ_d = occ_q;
      default: occ_d = occ_q;
    endcase

    // Output registers are loaded with the post-update head so m_data never passes through a mux.
    m_valid_d = (occ_d != OCC_EMPTY);
    m_data_d  = mem_d[head_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
      mem_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_q <= 16'd0;
    end else if (pop_s) begin
      word_count_q <= word_count_q + 16'd1;
    end else begin
      word_count_q <= word_count_q;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural upstream FIFO with registered read data,
// an in-order scoreboard on the output stream, and cycle-stamp checks on latency and throughput.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [15:0] word_count;
`endif

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         out_cnt = 0;
  int         rd_empty_cnt = 0;
  int         rel_cyc;
  int         snap_out;
  int         snap_empty;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         rd_cyc[$];
  int         out_cyc[$];

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Upstream FIFO: read data appears on fifo_dout the cycle after the strobe
  always @(posedge clk) begin
    if (fifo_rd_en && (fq.size() != 0)) fifo_dout <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // Output scoreboard and strobe bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (fifo_rd_en) rd_cyc.push_back(cyc);
    if (fifo_rd_en && fifo_empty) rd_empty_cnt++;
    if (m_valid && m_ready) begin
      out_cyc.push_back(cyc);
      out_cnt++;
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input bit expect_out);
    fq.push_back(v);
    fifo_empty = 1'b0;
    if (expect_out) exp_q.push_back(v);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    m_ready    = 1'b1;
    fifo_dout  = 8'h00;
    fifo_empty = 1'b1;

    // Reset with data waiting: no reads may be issued
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    tick(3);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
    check("rst_word_count", 32'(word_count), 32'd0);
`endif

    // Preloaded 0x11,0x22,0x33 with m_ready=1
    tick(1);
    rst = 1'b0;
    rel_cyc = cyc;
    rd_cyc.delete();
    out_cyc.delete();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    wait_drain("drain_t1", 20);
    check("t1_m_valid_after_drain", 32'(m_valid), 32'd0);
    check("t1_rd_count", 32'(rd_cyc.size()), 32'd3);
    if (rd_cyc.size() == 3 && out_cyc.size() == 3) begin
      check("t1_first_rd_cycle", 32'(rd_cyc[0]), 32'(rel_cyc));
      check("t1_rd_consecutive", 32'(rd_cyc[2] - rd_cyc[0]), 32'd2);
      check("t1_latency", 32'(out_cyc[0] - rd_cyc[0]), 32'd2);
      check("t1_out_consecutive", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
    end else begin
      check("t1_out_count", 32'(out_cyc.size()), 32'd3);
    end

    // 0xA0..0xA4 with the sink stalled: exactly two reads, head held
    m_ready = 1'b0;
    rd_cyc.delete();
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 1'b1);
    tick(8);
    check("t2_rd_count", 32'(rd_cyc.size()), 32'd2);
    check("t2_m_valid", 32'(m_valid), 32'd1);
    check("t2_m_data", 32'(m_data), 32'hA0);
    check("t2_fifo_left", 32'(fq.size()), 32'd3);
    tick(3);
    check("t2_m_data_held", 32'(m_data), 32'hA0);
    out_cyc.delete();
    m_ready = 1'b1;
    wait_drain("drain_t2", 30);
    check("t2_out_count", 32'(out_cyc.size()), 32'd5);
    if (out_cyc.size() == 5) check("t2_no_gaps", 32'(out_cyc[4] - out_cyc[0]), 32'd4);

    // One write per cycle while m_ready toggles 1,0
    snap_out   = out_cnt;
    snap_empty = rd_empty_cnt;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      push(8'h40 + 8'(i), 1'b1);
      m_ready = (i % 2 == 0);
    end
    tick(1);
    m_ready = 1'b1;
    wait_drain("drain_t3", 40);
    check("t3_out_count", 32'(out_cnt - snap_out), 32'd12);
    check("t3_rd_while_empty", 32'(rd_empty_cnt - snap_empty), 32'd0);

    // Reset while the buffer is full: outputs clear immediately, old words discarded
    m_ready = 1'b0;
    push(8'hC0, 1'b0);
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    tick(5);
    check("t4_full_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t4_rst_m_valid", 32'(m_valid), 32'd0);
    check("t4_rst_m_data", 32'(m_data), 32'd0);
    check("t4_rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
    check("t4_rst_word_count", 32'(word_count), 32'd0);
`endif
    fq.delete();
    push(8'h5A, 1'b1);
    m_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_drain("drain_t4", 20);
    tick(5);
    check("t4_idle_valid", 32'(m_valid), 32'd0);

    // 65537 words streamed back to back from a fresh reset
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    snap_out   = out_cnt;
    snap_empty = rd_empty_cnt;
    for (int i = 0; i < 65537; i++) begin
      push(8'(i * 7 + 3), 1'b1);
      tick(1);
    end
    wait_drain("drain_t5", 100);
    check("t5_out_count", 32'(out_cnt - snap_out), 32'd65537);
    check("t5_rd_while_empty", 32'(rd_empty_cnt - snap_empty), 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
    check("t5_word_count_wrap", 32'(word_count), 32'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
